// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-issue stage: widths, opcode encoding, request record.
package alu_pkg;

    localparam int DATA_W    = 64;
    localparam int OP_W      = 4;
    // Request tags up to this width are carried; alu_issue's TAG_W must not exceed it.
    localparam int TAG_W_MAX = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'h0,
        OP_1   = 4'h1,
        OP_2   = 4'h2,
        OP_3   = 4'h3,
        OP_4   = 4'h4,
        OP_5   = 4'h5,
        OP_6   = 4'h6,
        OP_7   = 4'h7,
        OP_8   = 4'h8,
        OP_9   = 4'h9,
        OP_A   = 4'hA,
        OP_B   = 4'hB,
        OP_C   = 4'hC,
        OP_D   = 4'hD,
        OP_E   = 4'hE,
        OP_F   = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        alu_op_e              op;
        logic [TAG_W_MAX-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count; head data is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage in front of the registered 64-bit ALU: request FIFO, credit-gated issue, in-order result buffer.
// Build option ALU_ISSUE_BYPASS_EN: an empty request FIFO lets a request go straight to the ALU at its accept edge.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int REQ_CW = $clog2(DEPTH) + 1;
    localparam int RES_CW = $clog2(RES_DEPTH) + 1;
    localparam int RES_W  = DATA_W + TAG_W;
    localparam logic [RES_CW:0] RES_LIM = (RES_CW + 1)'(RES_DEPTH);

    logic              r_alive;
    logic              r_s1;
    logic              r_s2;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [TAG_W-1:0]  r_s2_tag;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    alu_op_e           r_alu_op;

    alu_req_t          w_req_in;
    alu_req_t          w_req_head;
    alu_req_t          w_issue_req;
    logic [REQ_CW-1:0] w_req_count;
    logic              w_req_empty;
    logic              w_req_full;
    logic              w_req_push;
    logic              w_req_pop;
    logic              w_accept;
    logic              w_bypass;
    logic              w_issue;
    logic              w_credit;
    logic [RES_CW:0]   w_used;
    logic [RES_CW-1:0] w_res_count;
    logic [RES_W-1:0]  w_res_head;
    logic              w_res_pop;
    logic              w_unused_tag;

    always_comb begin
        w_req_in                  = '0;
        w_req_in.a                = in_a;
        w_req_in.b                = in_b;
        w_req_in.op               = alu_op_e'(in_op);
        w_req_in.tag[TAG_W-1:0]   = in_tag;
    end

    assign w_req_empty = (w_req_count == '0);
    assign w_req_full  = (w_req_count == REQ_CW'(DEPTH));

    // r_alive keeps in_ready low through reset and for the first edge after release.
    assign in_ready = r_alive && !w_req_full;
    assign w_accept = in_valid && in_ready;

    // Slots already committed downstream: buffered results plus both pipeline stages.
    assign w_used   = {1'b0, w_res_count} + {{RES_CW{1'b0}}, r_s1} + {{RES_CW{1'b0}}, r_s2};
    assign w_credit = (w_used < RES_LIM);

`ifdef ALU_ISSUE_BYPASS_EN
    assign w_bypass = w_req_empty && w_accept && w_credit;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_req_pop   = !w_req_empty && w_credit;
    assign w_req_push  = w_accept && !w_bypass;
    assign w_issue     = w_req_pop || w_bypass;
    assign w_issue_req = w_bypass ? w_req_in : w_req_head;

    // Tag bits above TAG_W are always zero-filled and never consumed.
    assign w_unused_tag = ^w_issue_req.tag;

    sync_fifo #(
        .WIDTH ($bits(alu_req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_push),
        .i_wdata (w_req_in),
        .i_pop   (w_req_pop),
        .o_rdata (w_req_head),
        .o_count (w_req_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive  <= 1'b0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s1_tag <= '0;
            r_s2_tag <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= OP_ADD;
        end else begin
            r_alive  <= 1'b1;
            r_s1     <= w_issue;
            r_s2     <= r_s1;
            r_s2_tag <= r_s1_tag;
            if (w_issue) begin
                r_alu_a  <= w_issue_req.a;
                r_alu_b  <= w_issue_req.b;
                r_alu_op <= w_issue_req.op;
                r_s1_tag <= w_issue_req.tag[TAG_W-1:0];
            end
        end
    end

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;

    assign out_valid = (w_res_count != '0);
    assign w_res_pop = out_valid && out_ready;

    // Credits bound occupancy, so the s2 write never needs a full check.
    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s2),
        .i_wdata ({alu_result, r_s2_tag}),
        .i_pop   (w_res_pop),
        .o_rdata (w_res_head),
        .o_count (w_res_count)
    );

    assign out_result = out_valid ? w_res_head[RES_W-1:TAG_W] : '0;
    assign out_tag    = out_valid ? w_res_head[TAG_W-1:0]     : '0;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU plus an in-order expected-result queue.
module tb_alu_issue;

    localparam int DEPTH     = 4;
    localparam int RES_DEPTH = 4;
    localparam int TAG_W     = 4;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam int EXP_LAT   = 2;
`else
    localparam int EXP_LAT   = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [63:0]       in_a = '0;
    logic [63:0]       in_b = '0;
    logic [3:0]        in_op = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [63:0]       alu_a;
    logic [63:0]       alu_b;
    logic [3:0]        alu_op;
    logic [63:0]       alu_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [63:0]       out_result;
    logic [TAG_W-1:0]  out_tag;

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[5:0];
            default: return a + b + {60'd0, op};
        endcase
    endfunction

    // Registered ALU: captures alu_* on every edge, exactly one cycle of latency.
    always @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_op);

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          out_cyc_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          max_out = 0;
    logic [63:0] last_res = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: drive, account for the coming posedge handshakes, advance to next negedge.
    task automatic step(input bit v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                        input logic [TAG_W-1:0] tg, input bit rdy, output bit acc);
        exp_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tg;
        out_ready = rdy;
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            e.res = alu_fn(a, b, op);
            e.tag = tg;
            exp_q.push_back(e);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_result", out_result, e.res);
                check_eq("out_tag", {60'd0, out_tag}, {60'd0, e.tag});
            end
            last_res = out_result;
            n_out++;
            out_cyc_q.push_back(cyc);
        end
        if (n_acc - n_out > max_out) max_out = n_acc - n_out;
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        bit acc;
        for (int k = 0; k < budget && exp_q.size() > 0; k++)
            step(1'b0, '0, '0, '0, '0, 1'b1, acc);
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_in_ready"},   in_ready,   0);
        check_eq({pfx, "_out_valid"},  out_valid,  0);
        check_eq({pfx, "_out_result"}, out_result, 0);
        check_eq({pfx, "_out_tag"},    out_tag,    0);
        check_eq({pfx, "_alu_a"},      alu_a,      0);
        check_eq({pfx, "_alu_b"},      alu_b,      0);
        check_eq({pfx, "_alu_op"},     alu_op,     0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int lat;
        int inr_low;
        int idx;
        int n0;
        int rnd_acc;
        int guard;
        logic [63:0] ra;
        logic [63:0] rb;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", in_ready, 1);

        // single request latency
        in_valid = 1'b1; in_a = 64'd5; in_b = 64'd7; in_op = 4'h0; in_tag = 4'd3; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("single_latency", lat, EXP_LAT);
        check_eq("single_result", out_result, 64'd12);
        check_eq("single_tag", {60'd0, out_tag}, 64'd3);
        @(negedge clk);
        @(negedge clk);
        check_eq("single_popped", out_valid, 0);

        // 8 back-to-back adds
        out_cyc_q.delete();
        inr_low = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 64'(i), 64'd100, 4'h0, TAG_W'(i), 1'b1, acc);
            if (!acc) inr_low++;
        end
        drain(30);
        check_eq("b2b_in_ready_low", inr_low, 0);
        check_eq("b2b_out_count", out_cyc_q.size(), 8);
        if (out_cyc_q.size() == 8)
            check_eq("b2b_one_per_cycle", out_cyc_q[7] - out_cyc_q[0], 7);

        // consumer stalled, 12 cycles of offered requests
        idx = 0;
        n0 = n_out;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 64'd1000 + 64'(idx), 64'(idx), 4'h1, TAG_W'(idx), 1'b0, acc);
            if (acc) idx++;
        end
        check_eq("stall_accepted", idx, DEPTH + RES_DEPTH);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        drain(60);
        check_eq("stall_drained", n_out - n0, DEPTH + RES_DEPTH);

        // 64-bit wrap
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 4'hA, 1'b1, acc);
        check_eq("wrap_accepted", acc, 1);
        last_res = 64'hDEAD;
        drain(20);
        check_eq("wrap_result", last_res, 64'd0);

        // reset with work in flight and buffered
        for (int i = 0; i < 4; i++) step(1'b1, 64'(i + 1), 64'd10, 4'h0, TAG_W'(i + 8), 1'b0, acc);
        step(1'b0, '0, '0, '0, '0, 1'b0, acc);
        check_eq("pre_reset_buffered", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        n_out = n_acc;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n0 = n_out;
        for (int k = 0; k < 10; k++) step(1'b0, '0, '0, '0, '0, 1'b1, acc);
        check_eq("post_reset_quiet", n_out - n0, 0);

        // random traffic
        rnd_acc = 0;
        guard = 0;
        n0 = n_out;
        while (rnd_acc < 1000 && guard < 20000) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            step($urandom_range(0, 99) < 70, ra, rb, 4'($urandom_range(0, 15)),
                 TAG_W'($urandom_range(0, 15)), $urandom_range(0, 99) < 60, acc);
            if (acc) rnd_acc++;
            guard++;
        end
        check_eq("rand_accepted", rnd_acc, 1000);
        drain(200);
        check_eq("rand_delivered", n_out - n0, rnd_acc);
        check_eq("outstanding_bound", max_out <= DEPTH + RES_DEPTH, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
